// File: rtl/erx_protocol_burst.sv
// ---------------------------------------------------------------------------
// erx_protocol_burst
// Elink RX protocol stage between the deserialiser and the MMU/filter.
// For each beat it:
//   - regenerates the destination address (a stride of 1 << datamode is added
//     for burst continuation beats),
//   - checks that bursts are legal (no orphan continuations, no more than
//     MAXBURST beats per burst),
//   - tags beats whose address targets this link ID as erx_rr.
// Accepted beats go through a 2-entry skid buffer. The buffer raises a
// registered wait toward the deserialiser when it is full.
//
// Ports:
//   clk, nreset             clock, asynchronous active-low reset
//   test_mode               consume and drop all incoming traffic
//   rx_access/rx_burst      incoming beat valid / continuation flag
//   rx_packet[PW-1:0]       incoming beat
//   rx_wait                 backpressure toward the deserialiser
//   erx_access/erx_packet   outgoing beat valid / packet
//   erx_rr                  outgoing beat is a read response to this link
//   erx_wait                downstream stall
//   burst_err/err_clear     sticky burst protocol error and its clear
//
// Optional feature (macro ERX_PROTOCOL_STATS_EN):
//   stat_beats[31:0]        saturating count of enqueued beats
//   stat_drops[15:0]        saturating count of beats dropped by the FSM
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module erx_protocol_burst #(
  parameter int          AW       = 32,
  parameter int          PW       = 3*AW+8,
  parameter logic [11:0] ID       = 12'h999,
  parameter int          MAXBURST = 16
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          test_mode,
  input  logic          rx_access,
  input  logic          rx_burst,
  input  logic [PW-1:0] rx_packet,
  output logic          rx_wait,
  output logic          erx_access,
  output logic [PW-1:0] erx_packet,
  output logic          erx_rr,
  input  logic          erx_wait,
  output logic          burst_err,
  input  logic          err_clear
`ifdef ERX_PROTOCOL_STATS_EN
  ,
  output logic [31:0]   stat_beats,
  output logic [15:0]   stat_drops
`endif
);

  typedef enum logic {IDLE, BURST} state_t;

  // The 8-bit beat counter wraps to 0 after 255 beats. With MAXBURST=256,
  // the truncated limit is therefore 0, and it matches exactly when the
  // 256th beat has been taken.
  localparam logic [7:0] MaxBeats = 8'(MAXBURST);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    beatCnt_q, beatCnt_d;
  logic [PW:0]   fifo_q [2];
  logic [PW:0]   fifo_d [2];
  logic [1:0]    fifoCount_q, fifoCount_d;
  logic          wait_q;
  logic          burstErr_q, burstErr_d;

  logic          accept;
  logic          live;
  logic          push;
  logic          pop;
  logic          drop;
  logic [AW-1:0] stride;
  logic [AW-1:0] genAddr;
  logic [PW-1:0] outPacket;
  logic          outRr;

  assign accept = rx_access & ~rx_wait;
  assign live   = accept & ~test_mode;
  assign stride = AW'(1) << rx_packet[2:1];
  assign pop    = erx_access & ~erx_wait;

  // Burst tracking. A beat with rx_burst=0 always starts a fresh burst,
  // whatever the current state is.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beatCnt_d = beatCnt_q;
    push      = 1'b0;
    drop      = 1'b0;
    genAddr   = rx_packet[AW+7:8];
    if (live) begin
      if (!rx_burst) begin
        addr_d    = genAddr;
        beatCnt_d = 8'd1;
        state_d   = BURST;
        push      = 1'b1;
      end else if (state_q == IDLE) begin
        drop = 1'b1;
      end else if (beatCnt_q == MaxBeats) begin
        drop    = 1'b1;
        state_d = IDLE;
      end else begin
        genAddr   = addr_q + stride;
        addr_d    = genAddr;
        beatCnt_d = beatCnt_q + 8'd1;
        push      = 1'b1;
      end
    end
  end

  always_comb begin
    outPacket           = rx_packet;
    outPacket[AW+7:8]   = genAddr;
  end

  assign outRr = (genAddr[AW-1:AW-12] == ID) & rx_packet[0];

  // Setting the error has priority over clearing it in the same cycle.
  always_comb begin
    burstErr_d = burstErr_q;
    if (drop) begin
      burstErr_d = 1'b1;
    end else if (err_clear) begin
      burstErr_d = 1'b0;
    end
  end

  // Shift-style skid buffer: entry 0 is always the head. A pop shifts
  // entry 1 down, and a push lands in the first free slot after the pop.
  always_comb begin
    fifo_d      = fifo_q;
    fifoCount_d = fifoCount_q;
    if (pop) begin
      fifo_d[0]   = fifo_q[1];
      fifoCount_d = fifoCount_q - 2'd1;
    end
    if (push) begin
      fifo_d[fifoCount_d[0]] = {outRr, outPacket};
      fifoCount_d            = fifoCount_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      beatCnt_q   <= '0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      fifoCount_q <= '0;
      wait_q      <= 1'b0;
      burstErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beatCnt_q   <= beatCnt_d;
      fifo_q      <= fifo_d;
      fifoCount_q <= fifoCount_d;
      wait_q      <= (fifoCount_d == 2'd2);
      burstErr_q  <= burstErr_d;
    end
  end

  // In test_mode every beat is swallowed, so the source must never be stalled.
  assign rx_wait                = wait_q & ~test_mode;
  assign erx_access             = (fifoCount_q != 2'd0);
  assign {erx_rr, erx_packet}   = fifo_q[0];
  assign burst_err              = burstErr_q;

`ifdef ERX_PROTOCOL_STATS_EN
  logic [31:0] statBeats_q;
  logic [15:0] statDrops_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      statBeats_q <= '0;
      statDrops_q <= '0;
    end else if (err_clear) begin
      statBeats_q <= '0;
      statDrops_q <= '0;
    end else begin
      if (push && (statBeats_q != '1)) begin
        statBeats_q <= statBeats_q + 32'd1;
      end
      if (drop && (statDrops_q != '1)) begin
        statDrops_q <= statDrops_q + 16'd1;
      end
    end
  end

  assign stat_beats = statBeats_q;
  assign stat_drops = statDrops_q;
`endif

endmodule

// File: doc/erx_protocol_burst.md
Name: erx_protocol_burst

Overview:
- Parametrised successor to the elink RX protocol stage. Sits between the RX deserialiser (packet-parallel side) and the MMU/filter.
- Regenerates destination addresses for burst beats using a datamode-dependent stride and supports 32- or 64-bit addressing.
- Checks burst legality, tags read responses addressed to this link, and provides a 2-entry skid buffer with wait backpressure toward the deserialiser.

Parameters:
- AW, 32, address width (32 or 64).
- PW, 3*AW+8, packet width. Field layout:
  - [0] write
  - [2:1] datamode
  - [7:3] ctrlmode
  - [AW+7:8] dstaddr
  - [2AW+7:AW+8] data
  - [PW-1:2AW+8] srcaddr
- ID, 12'h999, link ID compared against dstaddr[AW-1:AW-12].
- MAXBURST, 16, maximum beats per burst including the first beat (2..256).

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- test_mode  in  1  drop all traffic
- rx_access  in  1  beat valid
- rx_burst  in  1  beat is a continuation of the current burst (its dstaddr field is ignored)
- rx_packet  in  PW  beat packet
- rx_wait  out  1  registered backpressure; a beat is accepted only when rx_access=1 and rx_wait=0
- erx_access  out  1  output valid
- erx_packet  out  PW  output packet, bit 0 = write
- erx_rr  out  1  output beat is a read response to this link
- erx_wait  in  1  downstream stall
- burst_err  out  1  sticky burst protocol error
- err_clear  in  1  clears burst_err

Behaviour:
- Reset: asynchronous on nreset low. The following all clear to 0:
  - erx_access, erx_packet, erx_rr, rx_wait, burst_err
  - address register, beat counter, skid buffer
  - state returns to IDLE
- Accept: acc = rx_access & ~rx_wait.
- Address:
  - acc with rx_burst=0: address = rx_packet dstaddr.
  - acc with rx_burst=1: address = addr_reg + (1<<datamode), i.e. 1, 2, 4 or 8 bytes.
  - Arithmetic is modulo 2^AW; wrap-around past all-ones is legal and silent.
  - addr_reg updates only on an accepted, non-dropped beat.
- FSM with states IDLE and BURST; beat counter cnt is 8 bits.
  - IDLE, acc with rx_burst=0: load address, cnt=1, go to BURST, enqueue.
  - IDLE, acc with rx_burst=1: orphan continuation. Drop the beat, set burst_err, stay IDLE.
  - BURST, acc with rx_burst=1 and cnt<MAXBURST: increment address, cnt+1, enqueue.
  - BURST, acc with rx_burst=1 and cnt==MAXBURST: drop the beat, set burst_err, go to IDLE.
  - BURST, acc with rx_burst=0: start a new burst (same as the IDLE case, cnt=1).
- Output packet: input packet with dstaddr replaced by the generated address; all other fields pass through unchanged.
- erx_rr = (generated address[AW-1:AW-12]==ID) & write. It is computed at enqueue time and stored alongside the packet.
- Skid buffer: 2-entry FIFO.
  - Head entry drives erx_access/erx_packet/erx_rr.
  - Head pops when erx_access & ~erx_wait.
  - rx_wait is registered: rx_wait is 1 on the cycle after the FIFO count becomes 2 (i.e. rx_wait reflects the current count==2).
  - Simultaneous push and pop keeps the count unchanged.
  - Latency from accepted beat to erx_access is 1 cycle when the FIFO is empty.
- test_mode=1:
  - rx_wait is forced to 0 and all beats are consumed and dropped.
  - No enqueue, no FSM update, no error.
  - Entries already queued still drain.
- burst_err:
  - Set has priority over err_clear in the same cycle.
  - Otherwise err_clear=1 clears it on the next edge.
- Reset mid-burst: FSM returns to IDLE and the FIFO is emptied. A subsequent rx_burst=1 beat is then an orphan.

Optional Feature:
- Macro: ERX_PROTOCOL_STATS_EN.
- Defined:
  - Adds outputs stat_beats[31:0] (beats enqueued) and stat_drops[15:0] (beats dropped by the FSM, excluding test_mode drops).
  - Both counters saturate at all-ones, reset to 0 asynchronously, and are cleared synchronously by err_clear.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Single beat, datamode=3, dstaddr=0x80001000, erx_wait=0 -> erx_access high 1 cycle later with dstaddr=0x80001000 and erx_rr=0.
- Burst: first beat at 0x100 (datamode=2) followed by 3 rx_burst beats -> output addresses 0x100, 0x104, 0x108, 0x10C.
- Burst of MAXBURST+1 beats with MAXBURST=4 -> 4 beats output, 5th dropped, burst_err=1. err_clear then clears it. The next rx_burst beat is an orphan: dropped and burst_err set again.
- erx_wait held high while 3 beats are sent -> 2 beats queued, rx_wait=1, 3rd beat held by the source. Release erx_wait -> all 3 delivered in order.
- Write beat with dstaddr=0x999xxxxx and ID=12'h999 -> erx_rr=1. Same beat with write=0 -> erx_rr=0.
- Wrap-around: AW=32, base address 0xFFFFFFFC, datamode=2, one rx_burst beat -> second output address 0x00000000, no error.
